// File: rtl/axi_lite_gpio_slave.sv
// axi_lite_gpio_slave
// AXI4-Lite responder exposing the AXI GPIO register map: one or two GPIO
// banks with per-bit tri-state control and an interrupt on input change.
//
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   s_axi_aw*/w*/b*             AXI4-Lite write address/data/response
//   s_axi_ar*/r*                AXI4-Lite read address/data
//   gpio_i/gpio_o/gpio_t        channel 1 pins (tri bit 1 = input)
//   gpio2_i/gpio2_o/gpio2_t     channel 2 pins (only live when DUAL_CHANNEL)
//   irq_o                       registered level interrupt
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x000 DATA, 0x004 TRI, 0x008 DATA2, 0x00C TRI2,
//   0x11C GIER (bit 31), 0x120 ISR [1:0] (toggle-on-write), 0x128 IER [1:0]
module axi_lite_gpio_slave #(
  parameter int          GPIO_WIDTH   = 32,
  parameter logic        DUAL_CHANNEL = 1'b0,
  parameter logic        INTERRUPT_EN = 1'b1,
  parameter logic [31:0] DOUT_DEFAULT = 32'h0000_0000,
  parameter logic [31:0] TRI_DEFAULT  = 32'hFFFF_FFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [8:0]            s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [8:0]            s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_t,
  input  logic [GPIO_WIDTH-1:0] gpio2_i,
  output logic [GPIO_WIDTH-1:0] gpio2_o,
  output logic [GPIO_WIDTH-1:0] gpio2_t,
  output logic                  irq_o
);

  // Word indices (byte offset >> 2)
  localparam logic [6:0] IDX_DATA  = 7'h00;
  localparam logic [6:0] IDX_TRI   = 7'h01;
  localparam logic [6:0] IDX_DATA2 = 7'h02;
  localparam logic [6:0] IDX_TRI2  = 7'h03;
  localparam logic [6:0] IDX_GIER  = 7'h47;
  localparam logic [6:0] IDX_ISR   = 7'h48;
  localparam logic [6:0] IDX_IER   = 7'h4A;

  localparam logic [GPIO_WIDTH-1:0] DOUT_RST = DOUT_DEFAULT[GPIO_WIDTH-1:0];
  localparam logic [GPIO_WIDTH-1:0] TRI_RST  = TRI_DEFAULT[GPIO_WIDTH-1:0];
  // ISR[1] only exists with a second channel
  localparam logic [1:0] ISR_MASK = DUAL_CHANNEL ? 2'b11 : 2'b01;

  // Zero-extend a channel-wide value to the 32-bit bus width
  function automatic logic [31:0] widen(input logic [GPIO_WIDTH-1:0] v);
    widen = 32'h0000_0000;
    widen[GPIO_WIDTH-1:0] = v;
  endfunction

  // Replace the strobed bytes of old with the matching bytes of data
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    byte_merge = (old & ~m) | (data & m);
  endfunction

  // Channel state
  logic                  aw_held_r, w_held_r, bvalid_r, rvalid_r, irq_r;
  logic [6:0]            aw_addr_r;
  logic [31:0]           w_data_r, rdata_r;
  logic [3:0]            w_strb_r;
  logic [GPIO_WIDTH-1:0] data1_r, tri1_r, data2_r, tri2_r;
  logic [GPIO_WIDTH-1:0] data1_n, tri1_n, data2_n, tri2_n;
  logic                  gier_r, gier_n;
  logic [1:0]            isr_r, isr_n, ier_r, ier_n, isr_tog_s, isr_set_s;
  logic [GPIO_WIDTH-1:0] sync1_a_r, sync1_b_r, hist1_r;
  logic [GPIO_WIDTH-1:0] sync2_a_r, sync2_b_r, hist2_r;

  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [6:0]  wr_idx_s, rd_idx_s;
  logic [31:0] wr_data_s, rd_mux_s;
  logic [3:0]  wr_strb_s;
  logic [31:0] mrg_data1_s, mrg_tri1_s, mrg_data2_s, mrg_tri2_s;
  logic        unused_addr_bits_s;

  assign unused_addr_bits_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = !aw_held_r && !bvalid_r;
  assign s_axi_wready  = !w_held_r && !bvalid_r;
  assign s_axi_arready = !rvalid_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign irq_o         = irq_r;
  assign gpio_o        = data1_r;
  assign gpio_t        = tri1_r;

  // Channel 2 pins are parked (driven low, all inputs) without a second bank
  always_comb begin
    if (DUAL_CHANNEL) begin
      gpio2_o = data2_r;
      gpio2_t = tri2_r;
    end else begin
      gpio2_o = {GPIO_WIDTH{1'b0}};
      gpio2_t = {GPIO_WIDTH{1'b1}};
    end
  end

  // Handshakes and write-commit detection; held values take priority
  always_comb begin
    aw_hs_s  = s_axi_awvalid && s_axi_awready;
    w_hs_s   = s_axi_wvalid && s_axi_wready;
    ar_hs_s  = s_axi_arvalid && s_axi_arready;
    commit_s = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    rd_idx_s = s_axi_araddr[8:2];
    if (aw_held_r) begin
      wr_idx_s = aw_addr_r;
    end else begin
      wr_idx_s = s_axi_awaddr[8:2];
    end
    if (w_held_r) begin
      wr_data_s = w_data_r;
      wr_strb_s = w_strb_r;
    end else begin
      wr_data_s = s_axi_wdata;
      wr_strb_s = s_axi_wstrb;
    end
  end

  // Register next-state: byte-merged writes, ISR toggle, hardware set wins
  always_comb begin
    data1_n     = data1_r;
    tri1_n      = tri1_r;
    data2_n     = data2_r;
    tri2_n      = tri2_r;
    gier_n      = gier_r;
    ier_n       = ier_r;
    isr_tog_s   = 2'b00;
    mrg_data1_s = byte_merge(widen(data1_r), wr_data_s, wr_strb_s);
    mrg_tri1_s  = byte_merge(widen(tri1_r), wr_data_s, wr_strb_s);
    mrg_data2_s = byte_merge(widen(data2_r), wr_data_s, wr_strb_s);
    mrg_tri2_s  = byte_merge(widen(tri2_r), wr_data_s, wr_strb_s);
    isr_set_s   = {DUAL_CHANNEL && (sync2_b_r != hist2_r), sync1_b_r != hist1_r};
    if (commit_s) begin
      case (wr_idx_s)
        IDX_DATA: data1_n = mrg_data1_s[GPIO_WIDTH-1:0];
        IDX_TRI:  tri1_n  = mrg_tri1_s[GPIO_WIDTH-1:0];
        IDX_DATA2: begin
          if (DUAL_CHANNEL) data2_n = mrg_data2_s[GPIO_WIDTH-1:0];
          else              data2_n = data2_r;
        end
        IDX_TRI2: begin
          if (DUAL_CHANNEL) tri2_n = mrg_tri2_s[GPIO_WIDTH-1:0];
          else              tri2_n = tri2_r;
        end
        IDX_GIER: begin
          if (INTERRUPT_EN && wr_strb_s[3]) gier_n = wr_data_s[31];
          else                              gier_n = gier_r;
        end
        IDX_ISR: begin
          if (wr_strb_s[0]) isr_tog_s = wr_data_s[1:0] & ISR_MASK;
          else              isr_tog_s = 2'b00;
        end
        IDX_IER: begin
          if (INTERRUPT_EN && wr_strb_s[0]) ier_n = wr_data_s[1:0];
          else                              ier_n = ier_r;
        end
        default: data1_n = data1_r;
      endcase
    end else begin
      data1_n = data1_r;
    end
    if (INTERRUPT_EN) begin
      isr_n = (isr_r ^ isr_tog_s) | isr_set_s;
    end else begin
      isr_n = 2'b00;
    end
  end

  // Read mux: DATA shows the pin for input bits and the output register otherwise
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (rd_idx_s)
      IDX_DATA: rd_mux_s = widen((tri1_r & sync1_b_r) | (~tri1_r & data1_r));
      IDX_TRI:  rd_mux_s = widen(tri1_r);
      IDX_DATA2: begin
        if (DUAL_CHANNEL) rd_mux_s = widen((tri2_r & sync2_b_r) | (~tri2_r & data2_r));
        else              rd_mux_s = 32'h0000_0000;
      end
      IDX_TRI2: begin
        if (DUAL_CHANNEL) rd_mux_s = widen(tri2_r);
        else              rd_mux_s = 32'h0000_0000;
      end
      IDX_GIER: rd_mux_s = {gier_r, 31'h0000_0000};
      IDX_ISR:  rd_mux_s = {30'h0000_0000, isr_r};
      IDX_IER:  rd_mux_s = {30'h0000_0000, ier_r};
      default:  rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Write channel: AW/W holding registers and the B response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_held_r <= 1'b0;
      aw_addr_r <= 7'h00;
      w_held_r  <= 1'b0;
      w_data_r  <= 32'h0000_0000;
      w_strb_r  <= 4'h0;
      bvalid_r  <= 1'b0;
    end else if (commit_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      bvalid_r  <= 1'b1;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        aw_addr_r <= s_axi_awaddr[8:2];
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
      end
      if (bvalid_r && s_axi_bready) bvalid_r <= 1'b0;
    end
  end

  // Read channel: register data on AR handshake, hold until accepted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_mux_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  // Architectural GPIO and interrupt registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data1_r <= DOUT_RST;
      tri1_r  <= TRI_RST;
      data2_r <= DOUT_RST;
      tri2_r  <= TRI_RST;
      gier_r  <= 1'b0;
      isr_r   <= 2'b00;
      ier_r   <= 2'b00;
    end else begin
      data1_r <= data1_n;
      tri1_r  <= tri1_n;
      data2_r <= data2_n;
      tri2_r  <= tri2_n;
      gier_r  <= gier_n;
      isr_r   <= isr_n;
      ier_r   <= ier_n;
    end
  end

  // Two-flop input synchronizers plus history flop for change detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_a_r <= {GPIO_WIDTH{1'b0}};
      sync1_b_r <= {GPIO_WIDTH{1'b0}};
      hist1_r   <= {GPIO_WIDTH{1'b0}};
      sync2_a_r <= {GPIO_WIDTH{1'b0}};
      sync2_b_r <= {GPIO_WIDTH{1'b0}};
      hist2_r   <= {GPIO_WIDTH{1'b0}};
    end else begin
      sync1_a_r <= gpio_i;
      sync1_b_r <= sync1_a_r;
      hist1_r   <= sync1_b_r;
      sync2_a_r <= gpio2_i;
      sync2_b_r <= sync2_a_r;
      hist2_r   <= sync2_b_r;
    end
  end

  // Registered interrupt level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= INTERRUPT_EN && gier_r && |(isr_r & ier_r);
    end
  end

endmodule

// File: doc/axi_lite_gpio_slave.md
Name: axi_lite_gpio_slave

Overview:
AXI4-Lite responder that implements the AXI GPIO register map in native RTL. It is the slave end of the SoC's simple-bus-to-AXI-Lite GPIO bridge. It stands in for the vendor GPIO IP on simulation and non-Xilinx targets, with the same address map, reset defaults and interrupt semantics. It provides one or two GPIO banks with per-bit tri-state control and an interrupt on input change.

Parameters:
GPIO_WIDTH, 32, bits per channel (1..32)
DUAL_CHANNEL, 1'b0, enables channel 2 registers and pins
INTERRUPT_EN, 1'b1, enables ISR/IER/GIER logic; when 0, irq_o is held 0 and the interrupt registers read 0
DOUT_DEFAULT, 32'h0, reset value of both data output registers
TRI_DEFAULT, 32'hFFFF_FFFF, reset value of both tri registers (1 = input)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
s_axi_awaddr  in  9  write address
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  9  read address
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
gpio_i, gpio_o, gpio_t  in/out/out  GPIO_WIDTH  channel 1 pins
gpio2_i, gpio2_o, gpio2_t  in/out/out  GPIO_WIDTH  channel 2 pins
irq_o  out  1  level interrupt, registered

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - all valid outputs 0; awready, wready and arready 1; rdata 0.
  - gpio_o/gpio2_o = DOUT_DEFAULT[GPIO_WIDTH-1:0]; gpio_t/gpio2_t = TRI_DEFAULT.
  - GIER, ISR, IER cleared; irq_o 0; synchronizer and history flops cleared.
  - Any in-flight transaction is dropped.
- Register map (byte offsets; addr[1:0] ignored):
  - 0x000 GPIO_DATA, 0x004 GPIO_TRI, 0x008 GPIO2_DATA, 0x00C GPIO2_TRI.
  - 0x11C GIER: bit 31 only.
  - 0x120 IP_ISR: bits [1:0]. 0x128 IP_IER: bits [1:0].
  - Unmapped offsets: reads return 0, writes are ignored, response is OKAY.
- Write channel:
  - AW and W are accepted independently, each into a 1-entry holding register.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - The write commits on the edge where both address and data are available, whether held or handshaking that same cycle. bvalid rises after that edge, the holding registers clear, and bvalid holds until bready.
  - AW+W presented together with bready=1: bvalid high for exactly one cycle; the next AW can be accepted the cycle after bvalid drops.
- Write data rules:
  - Per-byte merge using wstrb; bits at or above GPIO_WIDTH are discarded.
  - ISR write is toggle-on-write: ISR ^= wdata[1:0], only when wstrb[0]=1.
- Read channel:
  - arready = !rvalid. On AR handshake, rdata is registered and rvalid rises the next cycle, holding until rready.
  - Single outstanding read. Read and write are fully concurrent.
  - A read that coincides with a write to the same register returns the pre-write value.
- DATA read returns, per bit: tri=1 gives the synchronized input; tri=0 gives the output register. Upper bits read 0.
- Inputs pass through a 2-flop synchronizer plus a history flop.
- Interrupts:
  - ISR[0] sets when the synchronized ch1 input != history. ISR[1] does the same for ch2 (only when DUAL_CHANNEL=1).
  - A hardware set wins over a same-cycle software toggle-clear.
  - irq_o (registered) = GIER[31] & |(ISR & IER).
- DUAL_CHANNEL=0: ch2 registers read 0 and writes are ignored; gpio2_o=0, gpio2_t=all ones; ISR[1] stays 0.
- gpio_o equals the DATA register and gpio_t equals the TRI register.

Test Plan:
- Reset then read 0x004 → rdata=0xFFFFFFFF, rresp=0, rvalid one cycle after AR handshake; gpio_o=0.
- Write TRI=0x0 then DATA=0xA5A5A5A5 with wstrb=4'b0011 → gpio_o=0x0000A5A5; read 0x000 returns 0x0000A5A5.
- W presented 3 cycles before AW, bready held low 4 cycles → wready drops after W accept; one commit; bvalid holds until bready; no second write.
- TRI=all ones, IER=1, GIER=0x80000000, toggle gpio_i bit 3 → ISR[0]=1 and irq_o=1 within 4 cycles. Write ISR=0x1 → irq_o=0. Write ISR=0x1 again with no change → irq_o=1 (toggle).
- DUAL_CHANNEL=0: write 0x008=0xFFFFFFFF then read → 0; gpio2_t=all ones. Read 0x050 → 0, rresp OKAY.
- Assert rst_ni low while bvalid=1 and rvalid=1 → both 0 after the edge; registers return to defaults.
